mvm_tile_dp: RTL and testbench

MVM_TILE_DP -- requirements
Module: mvm_tile_dp

---
 rtl/mvm_tile_dp.sv | 182 ++++++++++++++++++
 tb/tb_mvm_tile_dp.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_tile_dp.sv
// Crossbar-tile matrix-vector multiply: out[c] = sum_r in[r]*w[r][c], saturating per column.
// Latency XBAR_SIZE+NZ+1 cycles from start to out_valid; zero activations skip their MAC cycle.
module mvm_tile_dp #(
  parameter int XBAR_SIZE = 8,
  parameter int IN_BITS   = 16,
  parameter int WT_BITS   = 16,
  parameter int MULT_BITS = 16,
  parameter int ACC_BITS  = 24
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wt_wr_en,
  input  logic [$clog2(XBAR_SIZE)-1:0]   wt_wr_addr,
  input  logic [XBAR_SIZE*WT_BITS-1:0]   wt_wr_row,
  input  logic                           start,
  input  logic [XBAR_SIZE*IN_BITS-1:0]   in_vec,
  input  logic                           clear,
  output logic                           busy,
  output logic                           out_valid,
  output logic [XBAR_SIZE*ACC_BITS-1:0]  out_vec,
  output logic                           sat_flag,
  output logic                           wr_err
);

  localparam int AW = $clog2(XBAR_SIZE);
  localparam int PW = IN_BITS + WT_BITS;
  localparam int SW = ACC_BITS + 1;

  typedef enum logic [1:0] {IDLE, FETCH, MAC, DONE} state_t;

  state_t                        state;
  state_t                        state_nxt;
  logic [XBAR_SIZE*WT_BITS-1:0]  wt_mem [XBAR_SIZE];
  logic [XBAR_SIZE*IN_BITS-1:0]  act_vec;
  logic [AW-1:0]                 row;
  logic [IN_BITS-1:0]            act_cur;
  logic [IN_BITS-1:0]            act_reg;
  logic [XBAR_SIZE*WT_BITS-1:0]  wrow_reg;
  logic [ACC_BITS-1:0]           acc [XBAR_SIZE];
  logic [XBAR_SIZE-1:0]          sat;
  logic                          last_row;

  logic [PW-1:0]                 prod     [XBAR_SIZE];
  logic [SW-1:0]                 acc_sum  [XBAR_SIZE];
  logic [ACC_BITS-1:0]           acc_nxt  [XBAR_SIZE];
  logic [XBAR_SIZE-1:0]          ovf;

  logic launch, fetch_en, mac_en, done_en, row_step, wr_ok, wr_rej;

  assign act_cur  = act_vec[int'(row)*IN_BITS +: IN_BITS];
  assign last_row = (row == AW'(XBAR_SIZE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = FETCH;
        FETCH: begin
          if (act_cur != '0)  state_nxt = MAC;
          else if (last_row)  state_nxt = DONE;
        end
        MAC:     state_nxt = last_row ? DONE : FETCH;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // clear suppresses every action of the current state, including a pending write
  always_comb begin
    busy     = (state != IDLE);
    launch   = 1'b0;
    fetch_en = 1'b0;
    mac_en   = 1'b0;
    done_en  = 1'b0;
    row_step = 1'b0;
    wr_ok    = 1'b0;
    wr_rej   = wt_wr_en && (clear || (state != IDLE));
    if (!clear) begin
      case (state)
        IDLE: begin
          launch = start;
          wr_ok  = wt_wr_en;
        end
        FETCH: begin
          fetch_en = 1'b1;
          row_step = (act_cur == '0) && !last_row;
        end
        MAC: begin
          mac_en   = 1'b1;
          row_step = !last_row;
        end
        DONE:    done_en = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < XBAR_SIZE; i++) begin
        wt_mem[i] <= '0;
      end
    end else if (wr_ok) begin
      wt_mem[wt_wr_addr] <= wt_wr_row;
    end
  end

  // Product keeps its upper MULT_BITS; one spare sum bit detects overflow for clamping
  always_comb begin
    for (int c = 0; c < XBAR_SIZE; c++) begin
      prod[c]    = PW'(act_reg) * PW'(wrow_reg[c*WT_BITS +: WT_BITS]);
      acc_sum[c] = {1'b0, acc[c]} + SW'(prod[c][PW-1 -: MULT_BITS]);
      ovf[c]     = acc_sum[c][ACC_BITS];
      acc_nxt[c] = ovf[c] ? '1 : acc_sum[c][ACC_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_vec  <= '0;
      row      <= '0;
      act_reg  <= '0;
      wrow_reg <= '0;
      sat      <= '0;
      for (int c = 0; c < XBAR_SIZE; c++) begin
        acc[c] <= '0;
      end
    end else begin
      if (launch) begin
        act_vec <= in_vec;
        row     <= '0;
        sat     <= '0;
        for (int c = 0; c < XBAR_SIZE; c++) begin
          acc[c] <= '0;
        end
      end
      if (fetch_en) begin
        act_reg  <= act_cur;
        wrow_reg <= wt_mem[row];
      end
      if (row_step) begin
        row <= row + AW'(1);
      end
      if (mac_en) begin
        for (int c = 0; c < XBAR_SIZE; c++) begin
          acc[c] <= acc_nxt[c];
        end
        sat <= sat | ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      sat_flag  <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      out_valid <= done_en;
      wr_err    <= wr_rej;
      if (done_en) begin
        for (int c = 0; c < XBAR_SIZE; c++) begin
          out_vec[c*ACC_BITS +: ACC_BITS] <= acc[c];
        end
        sat_flag <= |sat;
      end
    end
  end

endmodule

// File: tb/tb_mvm_tile_dp.sv
// Bench for mvm_tile_dp: default tile plus a 16-bit-accumulator tile on the same stimulus.
module tb_mvm_tile_dp;

  localparam int N  = 8;
  localparam int IB = 16;
  localparam int WB = 16;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wt_wr_en = 1'b0;
  logic [2:0]        wt_wr_addr = '0;
  logic [N*WB-1:0]   wt_wr_row = '0;
  logic              start = 1'b0;
  logic [N*IB-1:0]   in_vec = '0;
  logic              clear = 1'b0;

  logic              busy_a, out_valid_a, sat_flag_a, wr_err_a;
  logic [N*24-1:0]   out_vec_a;
  logic              busy_b, out_valid_b, sat_flag_b, wr_err_b;
  logic [N*16-1:0]   out_vec_b;

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 1'b0;

  mvm_tile_dp u_dut_a (
    .clk(clk), .reset(reset), .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr),
    .wt_wr_row(wt_wr_row), .start(start), .in_vec(in_vec), .clear(clear),
    .busy(busy_a), .out_valid(out_valid_a), .out_vec(out_vec_a),
    .sat_flag(sat_flag_a), .wr_err(wr_err_a)
  );

  mvm_tile_dp #(.ACC_BITS(16)) u_dut_b (
    .clk(clk), .reset(reset), .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr),
    .wt_wr_row(wt_wr_row), .start(start), .in_vec(in_vec), .clear(clear),
    .busy(busy_b), .out_valid(out_valid_b), .out_vec(out_vec_b),
    .sat_flag(sat_flag_b), .wr_err(wr_err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WB-1:0]   m_wt [N][N];
  int              m_cnt = 0;
  logic [N*24-1:0] p24 = '0, e24 = '0;
  logic [N*16-1:0] p16 = '0, e16 = '0;
  bit              ps24, ps16, es24, es16, e_valid, e_werr;

  function automatic longint col_res(input int c, input int accb,
                                     input logic [N*IB-1:0] v, output bit s);
    longint acc, mx, a, w;
    acc = 0;
    mx  = (longint'(1) << accb) - 1;
    s   = 1'b0;
    for (int r = 0; r < N; r++) begin
      a   = longint'(v[r*IB +: IB]);
      w   = longint'(m_wt[r][c]);
      acc = acc + ((a * w) >> (IB + WB - MB));
      if (acc > mx) begin
        acc = mx;
        s   = 1'b1;
      end
    end
    return acc;
  endfunction

  function automatic int lat_of(input logic [N*IB-1:0] v);
    int nz = 0;
    for (int r = 0; r < N; r++) if (v[r*IB +: IB] != '0) nz++;
    return N + nz + 1;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) m_wt[r][c] = '0;
    m_cnt = 0; e24 = '0; e16 = '0; es24 = 0; es16 = 0; e_valid = 0; e_werr = 0;
  endtask

  initial begin
    longint v;
    bit s;
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        model_reset();
      end else begin
        e_valid = 1'b0;
        e_werr  = wt_wr_en && (clear || m_cnt != 0);
        if (clear) begin
          m_cnt = 0;
        end else if (m_cnt == 0) begin
          if (wt_wr_en)
            for (int c = 0; c < N; c++) m_wt[wt_wr_addr][c] = wt_wr_row[c*WB +: WB];
          if (start) begin
            ps24 = 0; ps16 = 0;
            for (int c = 0; c < N; c++) begin
              v = col_res(c, 24, in_vec, s); p24[c*24 +: 24] = v[23:0]; ps24 |= s;
              v = col_res(c, 16, in_vec, s); p16[c*16 +: 16] = v[15:0]; ps16 |= s;
            end
            m_cnt = lat_of(in_vec);
          end
        end else begin
          m_cnt--;
          if (m_cnt == 0) begin
            e_valid = 1'b1; e24 = p24; e16 = p16; es24 = ps24; es16 = ps16;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    wait (checking);
    forever begin
      @(negedge clk);
      chk("a.busy", busy_a, m_cnt != 0);
      chk("a.out_valid", out_valid_a, e_valid);
      chk("a.wr_err", wr_err_a, e_werr);
      chk("a.out_vec", out_vec_a, e24);
      chk("a.sat_flag", sat_flag_a, es24);
      chk("b.busy", busy_b, m_cnt != 0);
      chk("b.out_valid", out_valid_b, e_valid);
      chk("b.wr_err", wr_err_b, e_werr);
      chk("b.out_vec", out_vec_b, e16);
      chk("b.sat_flag", sat_flag_b, es16);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [WB-1:0] val);
    for (int r = 0; r < N; r++) begin
      wt_wr_en = 1'b1; wt_wr_addr = 3'(r); wt_wr_row = {N{val}};
      step();
    end
    wt_wr_en = 1'b0;
  endtask

  task automatic load_pattern();
    for (int r = 0; r < N; r++) begin
      wt_wr_en = 1'b1; wt_wr_addr = 3'(r);
      for (int c = 0; c < N; c++) wt_wr_row[c*WB +: WB] = 16'(((r + 1) << 12) | (c << 8));
      step();
    end
    wt_wr_en = 1'b0;
  endtask

  task automatic issue_start(input logic [N*IB-1:0] v);
    in_vec = v; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!out_valid_a && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run_mvm(input string nm, input logic [N*IB-1:0] v, input int exp_lat);
    int lat;
    issue_start(v);
    wait_done(0, lat);
    chk({nm, ".latency"}, lat, exp_lat);
  endtask

  initial begin
    int lat;
    int seen;
    logic [N*IB-1:0] v;

    #2 reset = 1'b0;
    checking = 1'b1;
    repeat (3) step();
    chk("rst.busy", busy_a, 1'b0);
    chk("rst.out_vec", out_vec_a, '0);
    chk("rst.sat_flag", sat_flag_b, 1'b0);
    reset = 1'b1;
    step();

    // all 0x8000: 8 * 0x4000 = 0x20000
    load_all(16'h8000);
    run_mvm("half", {N{16'h8000}}, 17);
    chk("half.col0", out_vec_a[23:0], 24'h020000);
    chk("half.col7", out_vec_a[191:168], 24'h020000);
    chk("half.sat", sat_flag_a, 1'b0);
    chk("half.b_col0", out_vec_b[15:0], 16'hFFFF);
    chk("half.b_sat", sat_flag_b, 1'b1);

    // all-zero activations: every row skipped
    run_mvm("zero", '0, 9);
    chk("zero.out", out_vec_a, '0);
    chk("zero.sat", sat_flag_b, 1'b0);

    // full-scale saturates the 16-bit tile
    load_all(16'hFFFF);
    run_mvm("full", {N{16'hFFFF}}, 17);
    chk("full.b_out", out_vec_b, {N{16'hFFFF}});
    chk("full.b_sat", sat_flag_b, 1'b1);
    chk("full.col0", out_vec_a[23:0], 24'h07FFF0);
    chk("full.sat", sat_flag_a, 1'b0);

    // mixed weights, sparse activations (rows 0, 2, 7 nonzero)
    load_pattern();
    v = '0;
    v[0*IB +: IB] = 16'h2000; v[2*IB +: IB] = 16'h4000; v[7*IB +: IB] = 16'h0001;
    run_mvm("mix", v, 12);
    chk("mix.col0", out_vec_a[23:0], 24'h000E00);
    chk("mix.col1", out_vec_a[47:24], 24'h000E60);

    // write attempted during FETCH is rejected
    issue_start({N{16'h0100}});
    wt_wr_en = 1'b1; wt_wr_addr = 3'd0; wt_wr_row = {N{16'hFFFF}};
    step();
    wt_wr_en = 1'b0;
    chk("wrerr.pulse", wr_err_a, 1'b1);
    wait_done(1, lat);
    chk("wrerr.latency", lat, 17);
    chk("wrerr.col0", out_vec_a[23:0], 24'h000240);

    // clear while in MAC at row 3
    issue_start({N{16'h0100}});
    repeat (7) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr.busy", busy_a, 1'b0);
    chk("clr.keep", out_vec_a[23:0], 24'h000240);
    seen = 0;
    repeat (20) begin
      step();
      if (out_valid_a) seen++;
    end
    chk("clr.no_valid", seen, 0);
    run_mvm("clr.after", {N{16'h0200}}, 17);
    chk("clr.after.col0", out_vec_a[23:0], 24'h000480);

    // reset mid-MVM wipes weights and outputs
    issue_start({N{16'h0100}});
    repeat (5) step();
    reset = 1'b0;
    #1;
    chk("mrst.busy", busy_a, 1'b0);
    chk("mrst.out_vec", out_vec_a, '0);
    repeat (2) step();
    reset = 1'b1;
    step();
    run_mvm("mrst.wt0", {N{16'h8000}}, 17);
    chk("mrst.wt0.out", out_vec_a, '0);
    load_all(16'h4000);
    run_mvm("reload", {N{16'h8000}}, 17);
    chk("reload.col0", out_vec_a[23:0], 24'h010000);
    chk("reload.b_sat", sat_flag_b, 1'b1);
    v = '0;
    v[0*IB +: IB] = 16'h8000;
    run_mvm("b2b", v, 10);
    chk("b2b.col3", out_vec_a[95:72], 24'h002000);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
